// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the per-frame player sequencer: state encoding,
// collision flag bit positions and default parameter values.
package frame_sequencer_pkg;

    // Encoding chosen so col_req and step_en are each a single state bit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_QUERY = 2'b01,
        ST_STEP  = 2'b10
    } state_e;

    localparam int COL_LEFT  = 0;
    localparam int COL_BOT   = 1;
    localparam int COL_RIGHT = 2;
    localparam int COL_TOP   = 3;
    localparam int COL_W     = 4;

    localparam int DEF_COL_TIMEOUT     = 64;
    localparam int DEF_JUMP_BUF_FRAMES = 4;

    localparam int WAIT_W  = 8;
    localparam int FRAME_W = 16;
    localparam int JBUF_W  = 4;

endpackage

// File: rtl/frame_sequencer_jump_buffer.sv
// Jump press buffer: a rising edge of the button arms a counter that keeps
// the jump pending for a number of player steps.
module jump_buffer
    import frame_sequencer_pkg::*;
#(
    parameter int JUMP_BUF_FRAMES = DEF_JUMP_BUF_FRAMES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic step,
    output logic pending
);

    logic              btn_prev_q, btn_prev_d;
    logic [JBUF_W-1:0] count_q, count_d;
    logic              rise;

    always_comb begin
        rise       = btn & ~btn_prev_q;
        btn_prev_d = btn;
        count_d    = count_q;
        // A fresh press overrides the decrement of a coincident step.
        if (rise) begin
            count_d = JBUF_W'(JUMP_BUF_FRAMES);
        end else if (step && (count_q != '0)) begin
            count_d = count_q - JBUF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
            count_q    <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            count_q    <= count_d;
        end
    end

    assign pending = (count_q != '0);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: collision lookup handshake, one-cycle player update
// strobe, frame counter and sticky overrun / lookup-timeout flags.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int COL_TIMEOUT     = DEF_COL_TIMEOUT,
    parameter int JUMP_BUF_FRAMES = DEF_JUMP_BUF_FRAMES
) (
    input  logic               sim_clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               pause,
    input  logic               btn_jump,
    output logic               col_req,
    input  logic               col_ack,
    input  logic [COL_W-1:0]   col_result,
    output logic               step_en,
    output logic               jump_r,
    output logic [COL_W-1:0]   player_col,
    output logic [FRAME_W-1:0] frame_count,
    output logic               overrun,
    output logic               col_timeout,
    output logic               busy
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(COL_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [COL_W-1:0]   player_col_q, player_col_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic               overrun_q, overrun_d;
    logic               col_timeout_q, col_timeout_d;
    logic               jump_pending;

    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            player_col_q  <= '0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            col_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            player_col_q  <= player_col_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            col_timeout_q <= col_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        player_col_d  = player_col_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        col_timeout_d = col_timeout_q;

        // A frame arriving while busy is dropped, only flagged.
        if (frame_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (frame_start && !pause) begin
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (col_ack) begin
                    player_col_d  = col_result;
                    frame_count_d = frame_count_q + FRAME_W'(1);
                    wait_d        = '0;
                    state_d       = ST_STEP;
                end else if (wait_q == WAIT_LAST) begin
                    player_col_d  = '0;
                    col_timeout_d = 1'b1;
                    frame_count_d = frame_count_q + FRAME_W'(1);
                    wait_d        = '0;
                    state_d       = ST_STEP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        col_req     = (state_q == ST_QUERY);
        step_en     = (state_q == ST_STEP);
        busy        = (state_q != ST_IDLE);
        jump_r      = step_en & jump_pending;
        player_col  = player_col_q;
        frame_count = frame_count_q;
        overrun     = overrun_q;
        col_timeout = col_timeout_q;
    end

    jump_buffer #(
        .JUMP_BUF_FRAMES(JUMP_BUF_FRAMES)
    ) u_jump_buffer (
        .clk    (sim_clk),
        .rst    (reset),
        .btn    (btn_jump),
        .step   (step_en),
        .pending(jump_pending)
    );

endmodule
